// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and bus constants shared by the I2C controller, the peripheral and their benches.
package i2c_pkg;
    localparam int   I2C_ADDR_W   = 7;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_AACK,
        S_WDATA,
        S_WACK,
        S_RDATA,
        S_RNACK,
        S_STOP,
        S_DONE
    } i2c_state_t;
endpackage

// File: rtl/i2c_clk_gen.sv
// i2c_clk_gen: divides clk into SCL quarter-period ticks and tracks the quarter index Q0..Q3.
module i2c_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    output logic       o_qtick,
    output logic [1:0] o_quarter
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_quarter;
    logic          w_tick;

    assign w_tick    = r_cnt == CW'(CLK_DIV - 1);
    assign o_qtick   = w_tick;
    assign o_quarter = r_quarter;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_quarter <= '0;
        end else if (i_clr) begin
            r_cnt     <= '0;
            r_quarter <= '0;
        end else if (w_tick) begin
            r_cnt     <= '0;
            r_quarter <= r_quarter + 2'd1;
        end else begin
            r_cnt     <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_controller.sv
// i2c_controller: single-byte I2C master running START, addr+R/W, ACK, data, ACK/NACK, STOP.
// Define I2C_CTRL_NACK_CNT_EN to add the saturating nack_count output.
module i2c_controller
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [I2C_ADDR_W-1:0] cmd_addr,
    input  logic                  cmd_rw,
    input  logic [7:0]            cmd_wdata,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic                  rsp_nack,
`ifdef I2C_CTRL_NACK_CNT_EN
    output logic [7:0]            nack_count,
`endif
    output logic                  scl,
    inout  wire                   sda
);
    i2c_state_t r_state;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       r_rw;
    logic       r_nack;
    logic       r_ready;
    logic       r_rsp_valid;
    logic       r_scl;
    logic       r_sda_low;
    logic       w_qtick;
    logic [1:0] w_q;
    logic       w_scl;
    logic       w_sda_low;
    logic       w_sample;
    logic       w_slot_end;

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state == S_IDLE),
        .o_qtick   (w_qtick),
        .o_quarter (w_q)
    );

    assign w_sample   = w_qtick && w_q == 2'd2;
    assign w_slot_end = w_qtick && w_q == 2'd3;

    // Pin levels for the current quarter; registered below so they lag the quarter by one clk.
    always_comb begin
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        case (r_state)
            S_START:                          begin w_scl = w_q != 2'd3; w_sda_low = w_q[1];      end
            S_STOP:                           begin w_scl = w_q[1];      w_sda_low = w_q != 2'd3; end
            S_ADDR, S_WDATA:                  begin w_scl = w_q[1];      w_sda_low = !r_shift[7]; end
            S_AACK, S_WACK, S_RDATA, S_RNACK: w_scl = w_q[1];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_bit       <= 3'd7;
            r_shift     <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rw        <= 1'b0;
            r_nack      <= 1'b0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_scl       <= 1'b1;
            r_sda_low   <= 1'b0;
        end else begin
            r_scl       <= w_scl;
            r_sda_low   <= w_sda_low;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (cmd_valid && r_ready) begin
                    r_state <= S_START;
                    r_ready <= 1'b0;
                    r_shift <= {cmd_addr, cmd_rw};
                    r_rw    <= cmd_rw;
                    r_wdata <= cmd_wdata;
                    r_bit   <= 3'd7;
                    r_rdata <= '0;
                    r_nack  <= 1'b0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    if (w_sample && (r_state == S_AACK || r_state == S_WACK))
                        r_nack <= sda;
                    if (w_sample && r_state == S_RDATA)
                        r_shift <= {r_shift[6:0], sda};
                    if (w_slot_end) begin
                        case (r_state)
                            S_START: r_state <= S_ADDR;
                            S_ADDR, S_WDATA: begin
                                r_shift <= {r_shift[6:0], 1'b0};
                                r_bit   <= r_bit - 3'd1;
                                if (r_bit == 3'd0)
                                    r_state <= (r_state == S_ADDR) ? S_AACK : S_WACK;
                            end
                            S_AACK: begin
                                r_state <= r_nack ? S_STOP : (r_rw == I2C_RW_READ ? S_RDATA : S_WDATA);
                                r_shift <= r_wdata;
                            end
                            S_RDATA: begin
                                r_bit <= r_bit - 3'd1;
                                if (r_bit == 3'd0) begin
                                    r_state <= S_RNACK;
                                    r_rdata <= r_shift;
                                end
                            end
                            S_WACK, S_RNACK: r_state <= S_STOP;
                            S_STOP: begin
                                r_state     <= S_DONE;
                                r_rsp_valid <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

`ifdef I2C_CTRL_NACK_CNT_EN
    logic [7:0] r_nack_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_nack_cnt <= '0;
        else if (r_rsp_valid && r_nack && r_nack_cnt != 8'hFF)
            r_nack_cnt <= r_nack_cnt + 8'd1;
    end

    assign nack_count = r_nack_cnt;
`endif

    assign cmd_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_nack  = r_nack;
    assign scl       = r_scl;
    assign sda       = r_sda_low ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: random single-byte I2C transactions against a bus-level slave at 7'h42
// and a transaction-level expectation of bus bytes, ACKs and responses.
module tb_i2c_controller;
    import i2c_pkg::*;

    localparam int         CLK_DIV    = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h42;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       cmd_ready, rsp_valid, rsp_nack, scl;
    logic [7:0] rsp_rdata;
    wire        sda;
`ifdef I2C_CTRL_NACK_CNT_EN
    logic [7:0] nack_count;
`endif

    int         n_checks = 0;
    int         n_pass = 0;
    logic       s_drive = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         m_bits = 0;
    int         m_nbytes = 0;
    logic [7:0] m_byte = '0;
    logic       m_sel = 1'b0;
    logic       m_rd = 1'b0;
    logic [7:0] slave_rbyte = '0;
    int         n_start = 0;
    int         n_stop = 0;
    logic [7:0] bus_bytes[$];
    logic       bus_acks[$];
    logic [7:0] last_rdata = '0;
    logic       last_nack = 1'b0;

    i2c_controller #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_rw    (cmd_rw),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
`ifdef I2C_CTRL_NACK_CNT_EN
        .nack_count(nack_count),
`endif
        .scl       (scl),
        .sda       (sda)
    );

    pullup (sda);
    assign sda = s_drive ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    // Bus-level slave and monitor: samples the pins once per clk, away from the active edge.
    always @(negedge clk) begin : bus_model
        if (prev_scl && scl && prev_sda && !sda) begin
            n_start++;
            m_bits = 0;
            m_nbytes = 0;
            s_drive = 1'b0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            n_stop++;
            m_sel = 1'b0;
            s_drive = 1'b0;
        end else if (!prev_scl && scl) begin
            if (m_bits < 8) begin
                m_byte = {m_byte[6:0], sda};
                m_bits++;
            end else begin
                bus_bytes.push_back(m_byte);
                bus_acks.push_back(sda);
                m_bits = 0;
                m_nbytes++;
            end
        end else if (prev_scl && !scl) begin
            if (m_bits == 8 && m_nbytes == 0) begin
                m_sel = m_byte[7:1] == SLAVE_ADDR;
                m_rd = m_byte[0];
                s_drive = m_sel;
            end else if (m_bits == 8)
                s_drive = m_sel && !m_rd;
            else
                s_drive = m_sel && m_rd && m_nbytes == 1 && !slave_rbyte[7 - m_bits];
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic clear_bus();
        bus_bytes.delete();
        bus_acks.delete();
        n_start = 0;
        n_stop = 0;
    endtask

    task automatic start_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd);
        int t = 0;
        while (!cmd_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", cmd_ready, 1);
        check("hold_rdata", rsp_rdata, last_rdata);
        check("hold_nack", rsp_nack, last_nack);
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_rw = rw;
        cmd_wdata = wd;
        @(negedge clk);
        check("ready_drop", cmd_ready, 0);
        cmd_valid = 1'b0;
        cmd_wdata = 8'($urandom);
    endtask

    task automatic finish_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd, input logic [7:0] rb);
        int t = 0;
        int busy_ready = 0;
        logic sel;
        logic [7:0] exp_rdata;
        sel = a == SLAVE_ADDR;
        exp_rdata = (sel && rw == I2C_RW_READ) ? rb : 8'h00;
        while (!rsp_valid && t < 3000) begin
            if (cmd_ready) busy_ready++;
            @(negedge clk);
            t++;
        end
        check("rsp_seen", rsp_valid, 1);
        check("busy_ready", busy_ready, 0);
        check("rsp_nack", rsp_nack, !sel);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("n_start", n_start, 1);
        check("n_stop", n_stop, 1);
        check("n_bytes", bus_bytes.size(), sel ? 2 : 1);
        if (bus_bytes.size() > 0) begin
            check("addr_byte", bus_bytes[0], {a, rw});
            check("addr_ack", bus_acks[0], !sel);
        end
        if (sel && bus_bytes.size() > 1) begin
            check("data_byte", bus_bytes[1], rw ? rb : wd);
            check("data_ack", bus_acks[1], rw);
        end
        @(negedge clk);
        check("rsp_pulse", rsp_valid, 0);
        check("ready_back", cmd_ready, 1);
        last_rdata = exp_rdata;
        last_nack = !sel;
        clear_bus();
    endtask

    task automatic do_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd, input logic [7:0] rb);
        slave_rbyte = rb;
        start_cmd(a, rw, wd);
        finish_cmd(a, rw, wd, rb);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_valid", rsp_valid, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        clear_bus();

        do_txn(SLAVE_ADDR, I2C_RW_WRITE, 8'h5A, 8'h00);
        do_txn(SLAVE_ADDR, I2C_RW_READ, 8'h00, 8'hC3);
        do_txn(7'h10, I2C_RW_WRITE, 8'h77, 8'h00);

        // A command held on cmd_valid while busy waits for the previous response.
        slave_rbyte = 8'h3C;
        start_cmd(SLAVE_ADDR, I2C_RW_WRITE, 8'h96);
        cmd_valid = 1'b1;
        cmd_addr = SLAVE_ADDR;
        cmd_rw = I2C_RW_READ;
        finish_cmd(SLAVE_ADDR, I2C_RW_WRITE, 8'h96, 8'h3C);
        @(negedge clk);
        check("b2b_accept", cmd_ready, 0);
        cmd_valid = 1'b0;
        finish_cmd(SLAVE_ADDR, I2C_RW_READ, 8'h00, 8'h3C);

        // Abort in the middle of the address byte, while sda is being pulled low.
        start_cmd(SLAVE_ADDR, I2C_RW_WRITE, 8'hA5);
        repeat (CLK_DIV * 16) @(negedge clk);
        check("pre_rst_sda", sda, 0);
        rst = 1'b0;
        #1;
        check("abort_scl", scl, 1);
        check("abort_sda", sda, 1);
        check("abort_ready", cmd_ready, 1);
        check("abort_valid", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_bus();
        last_rdata = 8'h00;
        last_nack = 1'b0;
        do_txn(SLAVE_ADDR, I2C_RW_WRITE, 8'hE1, 8'h00);

        for (int i = 0; i < 24; i++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom);
            do_txn(a, 1'($urandom), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

`ifdef I2C_CTRL_NACK_CNT_EN
        for (int i = 0; i < 300; i++) do_txn(7'h10, I2C_RW_WRITE, 8'($urandom), 8'h00);
        check("nack_sat", nack_count, 8'hFF);
        rst = 1'b0;
        #1;
        check("nack_rst", nack_count, 0);
        @(negedge clk);
        rst = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
